// File: rtl/mem_ctrl.sv
// mem_ctrl: memory-stage access controller for two external SRAMs and a UART
// that shares the RAM1 data bus.
//
// Ports:
//   clk_i, rst_i                 clock, async active-high reset
//   is_RAM1_i/is_UART_i/is_RAM2_i one-hot target select
//   addr_i, wdata_i              access address / store data
//   memread_i, memwrite_i        access type (both high = write)
//   ramN_addr_o                  SRAM address {2'b00, captured addr}
//   ramN_dout_o, ramN_doe_o      SRAM data out / bus drive enable
//   ramN_din_i                   SRAM data in
//   ramN_en_n_o/oe_n_o/we_n_o    SRAM strobes, active-low
//   uart_rdn_o, uart_wrn_o       UART strobes, active-low
//   uart_dready_i/tbre_i/tsre_i  UART status
//   mem1_res_o, mem2_res_o       registered read results
//   stall_o                      pipeline hold request (combinational)
//
// Build option: define UART_TIMEOUT_EN to bound the UART wait states with a
// 16-bit timer; timed-out reads return 16'hFFFF.
//
// state  | meaning
// IDLE   | accept request, answer 0xBF01 status reads in place
// R_ACC  | single-cycle SRAM read/write
// U_WR   | UART write strobe low, data on RAM1 bus
// U_WAIT | wait for transmitter empty
// U_RD   | wait for receive data, strobe rdn and capture
// DONE   | strobes idle, pipeline released

module mem_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        is_RAM1_i,
  input  logic        is_UART_i,
  input  logic        is_RAM2_i,
  input  logic [15:0] addr_i,
  input  logic [15:0] wdata_i,
  input  logic        memread_i,
  input  logic        memwrite_i,
  output logic [17:0] ram1_addr_o,
  output logic [17:0] ram2_addr_o,
  output logic [15:0] ram1_dout_o,
  output logic        ram1_doe_o,
  input  logic [15:0] ram1_din_i,
  output logic [15:0] ram2_dout_o,
  output logic        ram2_doe_o,
  input  logic [15:0] ram2_din_i,
  output logic        ram1_en_n_o,
  output logic        ram1_oe_n_o,
  output logic        ram1_we_n_o,
  output logic        ram2_en_n_o,
  output logic        ram2_oe_n_o,
  output logic        ram2_we_n_o,
  output logic        uart_rdn_o,
  output logic        uart_wrn_o,
  input  logic        uart_dready_i,
  input  logic        uart_tbre_i,
  input  logic        uart_tsre_i,
  output logic [15:0] mem1_res_o,
  output logic [15:0] mem2_res_o,
  output logic        stall_o
);

  typedef enum logic [2:0] {IDLE, R_ACC, U_WR, U_WAIT, U_RD, DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] addr_q, addr_d, wdata_q, wdata_d;
  logic        sel2_q, sel2_d, wr_q, wr_d;
  logic [15:0] res1_q, res1_d, res2_q, res2_d;
  logic        ram1_en_n_q, ram1_en_n_d, ram1_oe_n_q, ram1_oe_n_d, ram1_we_n_q, ram1_we_n_d;
  logic        ram2_en_n_q, ram2_en_n_d, ram2_oe_n_q, ram2_oe_n_d, ram2_we_n_q, ram2_we_n_d;
  logic        ram1_doe_q, ram1_doe_d, ram2_doe_q, ram2_doe_d;
  logic        wrn_q, wrn_d;
`ifdef UART_TIMEOUT_EN
  logic [15:0] tmr_q, tmr_d;
`endif

  logic req, ram_req, uart_req, uart_data, uart_imm, tx_empty, acc1, acc2;

  // UART accesses to any address other than the data register 0xBF00 are
  // completed in IDLE without stalling; only reads of 0xBF01 return status.
  // Treating them all as immediate avoids a permanent stall on stray addresses.
  assign req       = (memread_i | memwrite_i) & (is_RAM1_i | is_UART_i | is_RAM2_i);
  assign ram_req   = req & (is_RAM1_i | is_RAM2_i);
  assign uart_req  = req & is_UART_i & ~is_RAM1_i & ~is_RAM2_i;
  assign uart_data = (addr_i == 16'hBF00);
  assign uart_imm  = uart_req & ~uart_data;
  assign tx_empty  = uart_tbre_i & uart_tsre_i;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    sel2_d  = sel2_q;
    wr_d    = wr_q;
    res1_d  = res1_q;
    res2_d  = res2_q;
`ifdef UART_TIMEOUT_EN
    tmr_d   = tmr_q;
`endif
    case (state_q)
      IDLE: begin
        // Request is sampled continuously here and frozen once we leave.
        addr_d  = addr_i;
        wdata_d = wdata_i;
        sel2_d  = is_RAM2_i & ~is_RAM1_i;
        wr_d    = memwrite_i;
`ifdef UART_TIMEOUT_EN
        tmr_d   = 16'hFFFE;  // reaches 0 on the 65535th waiting cycle
`endif
        if (ram_req)
          state_d = R_ACC;
        else if (uart_req && uart_data)
          state_d = memwrite_i ? U_WR : U_RD;
        else if (uart_imm && !memwrite_i && addr_i == 16'hBF01)
          res1_d = {14'b0, uart_dready_i, tx_empty};
      end
      R_ACC: begin
        if (!wr_q) begin
          if (sel2_q) res2_d = ram2_din_i;
          else        res1_d = ram1_din_i;
        end
        state_d = DONE;
      end
      U_WR: state_d = U_WAIT;
      U_WAIT: begin
        if (tx_empty)
          state_d = DONE;
`ifdef UART_TIMEOUT_EN
        else if (tmr_q == 16'd0)
          state_d = DONE;
        else
          tmr_d = tmr_q - 16'd1;
`endif
      end
      U_RD: begin
        if (uart_dready_i) begin
          res1_d  = ram1_din_i;
          state_d = DONE;
        end
`ifdef UART_TIMEOUT_EN
        else if (tmr_q == 16'd0) begin
          res1_d  = 16'hFFFF;
          state_d = DONE;
        end else
          tmr_d = tmr_q - 16'd1;
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Strobes are registered: decode them from the next state so they line
    // up with the state they belong to.
    acc1        = (state_d == R_ACC) & ~sel2_d;
    acc2        = (state_d == R_ACC) &  sel2_d;
    ram1_en_n_d = ~acc1;
    ram1_oe_n_d = ~(acc1 & ~wr_d);
    ram1_we_n_d = ~(acc1 &  wr_d);
    ram1_doe_d  = (acc1 & wr_d) | (state_d == U_WR);
    ram2_en_n_d = ~acc2;
    ram2_oe_n_d = ~(acc2 & ~wr_d);
    ram2_we_n_d = ~(acc2 &  wr_d);
    ram2_doe_d  = acc2 & wr_d;
    wrn_d       = ~(state_d == U_WR);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      addr_q      <= 16'h0;
      wdata_q     <= 16'h0;
      sel2_q      <= 1'b0;
      wr_q        <= 1'b0;
      res1_q      <= 16'h0;
      res2_q      <= 16'h0;
      ram1_en_n_q <= 1'b1;
      ram1_oe_n_q <= 1'b1;
      ram1_we_n_q <= 1'b1;
      ram1_doe_q  <= 1'b0;
      ram2_en_n_q <= 1'b1;
      ram2_oe_n_q <= 1'b1;
      ram2_we_n_q <= 1'b1;
      ram2_doe_q  <= 1'b0;
      wrn_q       <= 1'b1;
`ifdef UART_TIMEOUT_EN
      tmr_q       <= 16'hFFFE;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      sel2_q      <= sel2_d;
      wr_q        <= wr_d;
      res1_q      <= res1_d;
      res2_q      <= res2_d;
      ram1_en_n_q <= ram1_en_n_d;
      ram1_oe_n_q <= ram1_oe_n_d;
      ram1_we_n_q <= ram1_we_n_d;
      ram1_doe_q  <= ram1_doe_d;
      ram2_en_n_q <= ram2_en_n_d;
      ram2_oe_n_q <= ram2_oe_n_d;
      ram2_we_n_q <= ram2_we_n_d;
      ram2_doe_q  <= ram2_doe_d;
      wrn_q       <= wrn_d;
`ifdef UART_TIMEOUT_EN
      tmr_q       <= tmr_d;
`endif
    end
  end

  assign ram1_addr_o = {2'b00, addr_q};
  assign ram2_addr_o = {2'b00, addr_q};
  assign ram1_dout_o = wdata_q;
  assign ram2_dout_o = wdata_q;
  assign ram1_doe_o  = ram1_doe_q;
  assign ram2_doe_o  = ram2_doe_q;
  assign ram1_en_n_o = ram1_en_n_q;
  assign ram1_oe_n_o = ram1_oe_n_q;
  assign ram1_we_n_o = ram1_we_n_q;
  assign ram2_en_n_o = ram2_en_n_q;
  assign ram2_oe_n_o = ram2_oe_n_q;
  assign ram2_we_n_o = ram2_we_n_q;
  assign uart_wrn_o  = wrn_q;
  // rdn follows dready within the U_RD cycle so the strobe and the capture
  // of ram1_din_i happen in the same cycle.
  assign uart_rdn_o  = ~((state_q == U_RD) & uart_dready_i);
  assign mem1_res_o  = res1_q;
  assign mem2_res_o  = res2_q;
  assign stall_o     = ~rst_i & (((state_q == IDLE) & req & ~uart_imm) |
                                 (state_q == R_ACC) | (state_q == U_WR) |
                                 (state_q == U_WAIT) | (state_q == U_RD));

endmodule
